// File: rtl/temp_pkg.sv
// Shared constants and FSM encoding for the temperature sampler slice.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package temp_pkg;

    localparam int TEMP_W       = 16;
    localparam int TEMP_TIMEOUT = 15;
    localparam int NUM_CH       = 4;
    localparam int CH_W         = 2;

    localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } state_t;

endpackage

// File: rtl/temp_sampler_if.sv
// Shared sensor bus: request strobe + channel out, response strobe + data back.
// Latency: n/a (wires only).
// Backpressure: none; the sensor answers with a single valid strobe per request.
interface temp_sampler_if #(
    parameter int W = temp_pkg::TEMP_W
) ();

    logic                       sens_req;
    logic [temp_pkg::CH_W-1:0]  sens_ch;
    logic                       sens_valid;
    logic [W-1:0]               sens_data;

    // Sampler side drives the request, sensor side drives the response.
    modport master (
        output sens_req,
        output sens_ch,
        input  sens_valid,
        input  sens_data
    );

    modport slave (
        input  sens_req,
        input  sens_ch,
        output sens_valid,
        output sens_data
    );

endinterface

// File: rtl/wait_timer.sv
// Counts WAIT cycles for one channel poll and flags the last allowed cycle.
// Latency: expired is combinational from the count; count updates on clk.
// Backpressure: none; clear has priority over enable, count saturates at TIMEOUT.
module wait_timer #(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic _rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int TW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

    logic [TW-1:0] cnt;

    // Count elapsed WAIT cycles, holding at TIMEOUT so the counter never wraps.
    always_ff @(posedge clk or negedge _rst) begin
        if (!_rst) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable && (cnt != TW'(TIMEOUT))) begin
            cnt <= cnt + TW'(1);
        end
    end

    // The count is zero in the first WAIT cycle, so TIMEOUT-1 marks the last one.
    assign expired = (cnt >= TW'(TIMEOUT - 1));

endmodule

// File: rtl/temp_sampler.sv
// Polls four temperature channels in turn over a shared sensor bus, one frame per start.
// Latency: 9 cycles start-to-frame_valid with immediate answers; 4*(1+TIMEOUT)+1 worst case.
// Backpressure: start is ignored while busy; a silent channel is skipped after TIMEOUT cycles.
module temp_sampler
    import temp_pkg::*;
#(
    parameter int W       = TEMP_W,
    parameter int TIMEOUT = TEMP_TIMEOUT
) (
    input  logic               clk,
    input  logic               _rst,
    input  logic               start,
    temp_sampler_if.master     sens,
    output logic [W-1:0]       temp1,
    output logic [W-1:0]       temp2,
    output logic [W-1:0]       temp3,
    output logic [W-1:0]       temp4,
    output logic               frame_valid,
    output logic               busy,
    output logic [NUM_CH-1:0]  err_mask
);

    state_t              state_q, state_d;
    logic [CH_W-1:0]     ch_q, ch_d;
    logic [NUM_CH-1:0]   err_q, err_d;
    logic [W-1:0]        temp_q [NUM_CH];

    logic                cap;
    logic                wait_done;
    logic                timer_clr;
    logic                timer_en;
    logic                timer_exp;

    logic                req_d, req_q;
    logic                fv_d, fv_q;
    logic                busy_d, busy_q;

    wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_wait_timer (
        .clk     (clk),
        ._rst    (_rst),
        .clear   (timer_clr),
        .enable  (timer_en),
        .expired (timer_exp)
    );

    // State, channel index, error mask and the strobe outputs all live in flops.
    always_ff @(posedge clk or negedge _rst) begin
        if (!_rst) begin
            state_q <= ST_IDLE;
            ch_q    <= '0;
            err_q   <= '0;
            req_q   <= 1'b0;
            fv_q    <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ch_q    <= ch_d;
            err_q   <= err_d;
            req_q   <= req_d;
            fv_q    <= fv_d;
            busy_q  <= busy_d;
        end
    end

    // Next state: a response beats a simultaneous timeout, and either one ends the poll.
    always_comb begin
        state_d   = state_q;
        ch_d      = ch_q;
        err_d     = err_q;
        cap       = 1'b0;
        wait_done = 1'b0;
        timer_clr = 1'b0;
        timer_en  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    ch_d    = '0;
                    err_d   = '0;
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                timer_clr = 1'b1;
                state_d   = ST_WAIT;
            end
            ST_WAIT: begin
                timer_en = 1'b1;
                if (sens.sens_valid) begin
                    cap       = 1'b1;
                    wait_done = 1'b1;
                end else if (timer_exp) begin
                    err_d[ch_q] = 1'b1;
                    wait_done   = 1'b1;
                end
                if (wait_done) begin
                    if (ch_q == LAST_CH) begin
                        state_d = ST_DONE;
                    end else begin
                        ch_d    = ch_q + CH_W'(1);
                        state_d = ST_REQ;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs are decoded from the next state so they line up with the registered state.
    always_comb begin
        req_d  = (state_d == ST_REQ);
        fv_d   = (state_d == ST_DONE);
        busy_d = (state_d != ST_IDLE);
    end

    // Readings are stored as-is; only an accepted response in WAIT writes a slot.
    always_ff @(posedge clk or negedge _rst) begin
        if (!_rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                temp_q[i] <= '0;
            end
        end else if (cap) begin
            temp_q[ch_q] <= sens.sens_data;
        end
    end

    assign sens.sens_req = req_q;
    assign sens.sens_ch  = ch_q;
    assign temp1         = temp_q[0];
    assign temp2         = temp_q[1];
    assign temp3         = temp_q[2];
    assign temp4         = temp_q[3];
    assign frame_valid   = fv_q;
    assign busy          = busy_q;
    assign err_mask      = err_q;

endmodule

// File: tb/tb_temp_sampler.sv
// Directed bench for temp_sampler: a sensor responder answers each poll after a chosen delay,
// expected frames are queued at launch and checked when frame_valid fires.
module tb_temp_sampler;

    localparam int W       = 16;
    localparam int TIMEOUT = 15;
    localparam int BUDGET  = 2 * TIMEOUT + 10;

    typedef struct {
        logic [3:0][W-1:0] t;
        logic [3:0]        err;
        int                len;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [W-1:0]  temp1, temp2, temp3, temp4;
    logic          frame_valid;
    logic          busy;
    logic [3:0]    err_mask;

    temp_sampler_if #(.W(W)) sens ();

    temp_sampler #(
        .W       (W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk         (clk),
        ._rst        (rst_n),
        .start       (start),
        .sens        (sens),
        .temp1       (temp1),
        .temp2       (temp2),
        .temp3       (temp3),
        .temp4       (temp4),
        .frame_valid (frame_valid),
        .busy        (busy),
        .err_mask    (err_mask)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int                checks   = 0;
    int                failures = 0;
    exp_t              sb [$];
    logic [3:0][W-1:0] model_t;
    logic [3:0]        model_err;
    logic [W-1:0]      ans_dat [4];
    int                ans_cyc [4];
    int                last_fv;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_req();
        int b = 0;
        while (sens.sens_req !== 1'b1 && b < BUDGET) begin
            step();
            b++;
        end
    endtask

    // Run one frame with answers from ans_dat/ans_cyc (cycle 0 = never answer).
    task automatic run_frame(input bit launch, input bit hold, input int pulse_ch);
        exp_t e;
        exp_t got;
        int   c0;
        int   b;
        bit   answers;
        e.len = 1;
        e.err = '0;
        for (int c = 0; c < 4; c++) begin
            if (ans_cyc[c] >= 1 && ans_cyc[c] <= TIMEOUT) begin
                model_t[c] = ans_dat[c];
                e.len += 1 + ans_cyc[c];
            end else begin
                e.err[c] = 1'b1;
                e.len += 1 + TIMEOUT;
            end
        end
        e.t       = model_t;
        model_err = e.err;
        sb.push_back(e);

        if (launch) begin
            start = 1'b1;
            step();
            c0 = cyc;
        end else begin
            c0 = last_fv + 2;
        end

        for (int c = 0; c < 4; c++) begin
            wait_req();
            chk("req_seen", {63'd0, sens.sens_req}, 64'd1);
            chk("sens_ch", {62'd0, sens.sens_ch}, 64'(c));
            if (c == 0) start = hold;
            step();
            chk("req_one_cycle", {63'd0, sens.sens_req}, 64'd0);
            if (pulse_ch == c) start = 1'b1;
            answers = (ans_cyc[c] >= 1 && ans_cyc[c] <= TIMEOUT);
            if (answers) begin
                for (int k = 1; k < ans_cyc[c]; k++) begin
                    step();
                    if (pulse_ch == c) start = 1'b0;
                end
                sens.sens_valid = 1'b1;
                sens.sens_data  = ans_dat[c];
                step();
                sens.sens_valid = 1'b0;
                sens.sens_data  = '0;
                if (pulse_ch == c) start = 1'b0;
            end else if (pulse_ch == c) begin
                step();
                start = 1'b0;
            end
        end

        b = 0;
        while (frame_valid !== 1'b1 && b < BUDGET) begin
            step();
            b++;
        end
        chk("frame_valid_seen", {63'd0, frame_valid}, 64'd1);
        last_fv = cyc;
        chk("sb_nonempty", 64'(sb.size()), 64'd1);
        if (sb.size() != 0) begin
            got = sb.pop_front();
            chk("latency", 64'(cyc - c0 + 1), 64'(got.len));
            chk("temp1", 64'(temp1), 64'(got.t[0]));
            chk("temp2", 64'(temp2), 64'(got.t[1]));
            chk("temp3", 64'(temp3), 64'(got.t[2]));
            chk("temp4", 64'(temp4), 64'(got.t[3]));
            chk("err_mask", 64'(err_mask), 64'(got.err));
        end
        step();
        chk("frame_valid_pulse", {63'd0, frame_valid}, 64'd0);
        chk("busy_idle", {63'd0, busy}, 64'd0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_temp1"}, 64'(temp1), 64'd0);
        chk({tag, "_temp2"}, 64'(temp2), 64'd0);
        chk({tag, "_temp3"}, 64'(temp3), 64'd0);
        chk({tag, "_temp4"}, 64'(temp4), 64'd0);
        chk({tag, "_err"}, 64'(err_mask), 64'd0);
        chk({tag, "_busy"}, {63'd0, busy}, 64'd0);
        chk({tag, "_fv"}, {63'd0, frame_valid}, 64'd0);
        chk({tag, "_req"}, {63'd0, sens.sens_req}, 64'd0);
        chk({tag, "_ch"}, {62'd0, sens.sens_ch}, 64'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n           = 1'b0;
        start           = 1'b0;
        sens.sens_valid = 1'b0;
        sens.sens_data  = '0;
        model_t         = '0;
        model_err       = '0;
        last_fv         = 0;
        repeat (3) step();
        chk_all_zero("reset");
        rst_n = 1'b1;

        // Immediate answers 2,2,4,4.
        ans_dat = '{16'd2, 16'd2, 16'd4, 16'd4};
        ans_cyc = '{1, 1, 1, 1};
        run_frame(1'b1, 1'b0, -1);

        // Mixed delays; leaves temp3 = 7.
        ans_dat = '{16'd20, 16'd21, 16'd7, 16'd23};
        ans_cyc = '{3, 1, 2, 5};
        run_frame(1'b1, 1'b0, -1);

        // Channel 2 silent: temp3 keeps 7, err_mask = 0100, 23 cycles.
        ans_dat = '{16'd10, 16'd11, 16'd12, 16'd13};
        ans_cyc = '{1, 1, 0, 1};
        run_frame(1'b1, 1'b0, -1);

        // Answer on the last allowed WAIT cycle of channel 0 wins over the timeout.
        ans_dat = '{16'd99, 16'd5, 16'd6, 16'd8};
        ans_cyc = '{TIMEOUT, 1, 1, 1};
        run_frame(1'b1, 1'b0, -1);

        // Start pulsed during channel 1 WAIT must not restart the frame.
        ans_dat = '{16'd40, 16'd41, 16'd42, 16'd43};
        ans_cyc = '{1, 3, 1, 1};
        run_frame(1'b1, 1'b0, 1);
        repeat (3) begin
            step();
            chk("stay_idle_busy", {63'd0, busy}, 64'd0);
            chk("stay_idle_req", {63'd0, sens.sens_req}, 64'd0);
        end

        // Stray response in IDLE changes nothing.
        sens.sens_valid = 1'b1;
        sens.sens_data  = 16'd55;
        step();
        sens.sens_valid = 1'b0;
        sens.sens_data  = '0;
        step();
        chk("stray_temp1", 64'(temp1), 64'(model_t[0]));
        chk("stray_temp2", 64'(temp2), 64'(model_t[1]));
        chk("stray_temp3", 64'(temp3), 64'(model_t[2]));
        chk("stray_temp4", 64'(temp4), 64'(model_t[3]));
        chk("stray_err", 64'(err_mask), 64'(model_err));
        chk("stray_busy", {63'd0, busy}, 64'd0);

        // Back-to-back frames with start held: all-timeout worst case, then a normal frame.
        ans_dat = '{16'd0, 16'd0, 16'd0, 16'd0};
        ans_cyc = '{0, 0, 0, 0};
        run_frame(1'b1, 1'b1, -1);
        ans_dat = '{16'd1, 16'd2, 16'd3, 16'd4};
        ans_cyc = '{2, 2, 2, 2};
        run_frame(1'b0, 1'b0, -1);

        // Reset during channel 3 WAIT after channels 0..2 were captured.
        start = 1'b1;
        step();
        for (int c = 0; c < 3; c++) begin
            wait_req();
            if (c == 0) start = 1'b0;
            step();
            sens.sens_valid = 1'b1;
            sens.sens_data  = 16'(30 + c);
            step();
            sens.sens_valid = 1'b0;
            sens.sens_data  = '0;
        end
        wait_req();
        chk("rst_pre_ch", {62'd0, sens.sens_ch}, 64'd3);
        step();
        step();
        chk("rst_pre_temp3", 64'(temp3), 64'd32);
        chk("rst_pre_busy", {63'd0, busy}, 64'd1);
        rst_n = 1'b0;
        #1;
        chk_all_zero("midrst");
        repeat (3) begin
            step();
            chk("rst_hold_fv", {63'd0, frame_valid}, 64'd0);
        end
        model_t   = '0;
        model_err = '0;
        rst_n     = 1'b1;

        // Fresh frame right after reset release, start seen on the first edge.
        ans_dat = '{16'd70, 16'd71, 16'd72, 16'd73};
        ans_cyc = '{1, 0, 4, TIMEOUT};
        run_frame(1'b1, 1'b0, -1);
        step();
        chk("final_idle", {63'd0, busy}, 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/temp_sampler.md
TEMP_SAMPLER -- requirements
Module: temp_sampler

Interface
REQ-001 Parameter W, default 16: width of every temperature sample and output register.
REQ-002 Parameter TIMEOUT, default 15: maximum WAIT cycles per channel before the channel is skipped.
REQ-003 The block SHALL use one clock, clk; reset _rst is asynchronous and active-low.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 _rst  input  1  asynchronous active-low reset.
REQ-006 start  input  1  request one acquisition frame; sampled only in IDLE.
REQ-007 sens_req  output  1  one-cycle request strobe to the shared sensor bus.
REQ-008 sens_ch  output  2  channel being polled; 0..3.
REQ-009 sens_valid  input  1  sensor response strobe; sens_data is valid in the same cycle.
REQ-010 sens_data  input  W  unsigned temperature reading.
REQ-011 temp1, temp2, temp3, temp4  output  W each  latest accepted reading of channels 0..3; these feed the downstream threshold comparator directly.
REQ-012 frame_valid  output  1  one-cycle pulse when all four channels have been processed.
REQ-013 busy  output  1  high in every state except IDLE.
REQ-014 err_mask  output  4  bit n set when channel n timed out in the current or last frame.

Function
REQ-015 The FSM SHALL have the states IDLE, REQ, WAIT and DONE, with a 2-bit channel index ch.
REQ-016 IDLE: when start=1, set ch=0, clear err_mask and go to REQ; otherwise remain in IDLE.
REQ-017 REQ: assert sens_req=1 and sens_ch=ch for exactly one cycle, clear the wait timer and go to WAIT.
REQ-018 WAIT, sens_valid=1: load sens_data into temp(ch+1) on that edge.
REQ-019 WAIT, TIMEOUT cycles elapsed without sens_valid: leave temp(ch+1) unchanged and set err_mask[ch].
REQ-020 After either WAIT exit: if ch=3 go to DONE; otherwise increment ch and go to REQ.
REQ-021 sens_valid and timer expiry in the same cycle: sens_valid wins, with data captured and no error bit set.
REQ-022 sens_valid outside WAIT SHALL be ignored, with no register change.
REQ-023 DONE: assert frame_valid=1 for one cycle, then go to IDLE.
REQ-024 start while busy=1 SHALL be ignored; start held high in IDLE starts back-to-back frames, one per IDLE visit.
REQ-025 Latency: with sens_valid in the first WAIT cycle of every channel, frame_valid SHALL be high in the 9th cycle after the edge sampling start.
REQ-026 Worst-case latency: all channels time out, giving a frame length of 4*(1+TIMEOUT)+1 cycles.
REQ-027 The wait timer SHALL be ceil(log2(TIMEOUT+1)) bits wide, saturate at TIMEOUT, and never wrap.
REQ-028 temp1..temp4 and err_mask SHALL hold their values between frames; sens_data is stored unmodified with no clamping.
REQ-029 sens_ch SHALL equal ch in every state; sens_req SHALL be high only in REQ.

Reset
REQ-030 While _rst=0: state=IDLE, ch=0, timer=0, temp1..temp4=0, err_mask=0, sens_req=0, frame_valid=0, busy=0.
REQ-031 Assertion of _rst mid-frame SHALL abort the frame immediately, with no frame_valid pulse; partial captures are lost to the reset values.
REQ-032 After _rst deasserts, the first start SHALL be honoured on the first rising edge.

Structure
REQ-033 A shared package temp_pkg SHALL hold the default W, the default TIMEOUT, the channel count 4, and the FSM state encoding.
REQ-034 The per-channel timeout counter SHALL be a sub-module, wait_timer, with clear, enable, expired and parameter TIMEOUT.
REQ-035 temp_sampler SHALL contain the FSM, channel index, and output registers; all outputs are registered.

Verification
REQ-036 Reset then start; sensor answers 2,2,4,4 in the first WAIT cycle -> temp1..4=2,2,4,4, err_mask=0, frame_valid at cycle 9.
REQ-037 Channel 2 never answers; others answer 10,11,_,13, with temp3 previously 7 -> temp3 stays 7, err_mask=4'b0100, frame_valid at cycle 1+2+2+16+2=23.
REQ-038 sens_valid with data 99 on exactly the 15th WAIT cycle of channel 0 -> temp1=99, err_mask[0]=0.
REQ-039 start pulsed during WAIT of channel 1, plus sens_valid=1 with data 55 during IDLE -> no restart, temp registers unchanged by the stray valid.
REQ-040 _rst asserted during channel 3 WAIT after temp1..3 were captured -> all outputs 0 immediately, no frame_valid, and a fresh frame completes normally afterwards.
